conv_loop_ctrl: RTL and testbench

Loop sequencer for the convolution address datapath. Generates the six nested loop indices (i filter, j output row, k output column, m kernel row, n kernel column, l input channel) and the enable for the address-iterator stage, one tuple per cycle. It also flags accumulator boundaries and padding validity for the MAC stage. It sits between the layer-level control (start/done) and the address iterator / MAC pipeline, and honours a downstream stall.

---
 rtl/conv_loop_ctrl.sv | 157 +++++++++++++++
 tb/tb_conv_loop_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: six-deep loop sequencer for the convolution address datapath.
// Emits one (i,j,k,m,n,l) tuple per cycle while running and holds it on a stall.
// It also flags accumulator boundaries and padding validity for the MAC stage.
module conv_loop_ctrl #(
  parameter int BYTE            = 8,
  parameter int CONV_DIM_IMG    = 32,
  parameter int CONV_DIM_OUT    = 32,
  parameter int CONV_DIM_KERNEL = 5,
  parameter int CONV_DIM_CH     = 3,
  parameter int CONV_OUT_CH     = 6,
  parameter int STRIDE          = 1,
  parameter int PADDING         = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  output logic            busy,
  output logic            done,
  output logic            iter_en,
  output logic [BYTE-1:0] i,
  output logic [BYTE-1:0] j,
  output logic [BYTE-1:0] k,
  output logic [BYTE-1:0] m,
  output logic [BYTE-1:0] n,
  output logic [BYTE-1:0] l,
  output logic            acc_clr,
  output logic            acc_last,
  output logic            in_bounds
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [BYTE-1:0] ONE   = BYTE'(1);
  localparam logic [BYTE-1:0] ZERO  = '0;
  localparam logic [BYTE-1:0] L_MAX = BYTE'(CONV_DIM_CH - 1);
  localparam logic [BYTE-1:0] K_MAX = BYTE'(CONV_DIM_KERNEL - 1);
  localparam logic [BYTE-1:0] O_MAX = BYTE'(CONV_DIM_OUT - 1);
  localparam logic [BYTE-1:0] I_MAX = BYTE'(CONV_OUT_CH - 1);

  localparam logic [15:0] STRIDE16 = 16'(STRIDE);
  localparam logic [15:0] PAD16    = 16'(PADDING);
  localparam logic [15:0] IMG16    = 16'(CONV_DIM_IMG);

  state_t          state_q, state_d;
  logic [BYTE-1:0] i_q, j_q, k_q, m_q, n_q, l_q;
  logic [BYTE-1:0] i_d, j_d, k_d, m_d, n_d, l_d;

  logic            wrap_l, wrap_n, wrap_m, wrap_k, wrap_j, wrap_i;
  logic            final_tuple;
  logic            run;
  logic [15:0]     row, col;

  // A padded coordinate is valid only if it falls inside [PADDING, PADDING+IMG).
  // The lower-bound test comes first so the subtraction is only meaningful
  // when it cannot underflow.
  function automatic logic axis_ok(input logic [15:0] pos);
    return (pos >= PAD16) && ((pos - PAD16) < IMG16);
  endfunction

  assign wrap_l      = (l_q == L_MAX);
  assign wrap_n      = (n_q == K_MAX);
  assign wrap_m      = (m_q == K_MAX);
  assign wrap_k      = (k_q == O_MAX);
  assign wrap_j      = (j_q == O_MAX);
  assign wrap_i      = (i_q == I_MAX);
  assign final_tuple = wrap_l && wrap_n && wrap_m && wrap_k && wrap_j && wrap_i;

  // State and index registers; reset aborts any pass without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= ZERO;
      j_q     <= ZERO;
      k_q     <= ZERO;
      m_q     <= ZERO;
      n_q     <= ZERO;
      l_q     <= ZERO;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      m_q     <= m_d;
      n_q     <= n_d;
      l_q     <= l_d;
    end
  end

  // Next state and odometer-style index advance, l innermost through i outermost.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    m_d     = m_q;
    n_d     = n_q;
    l_d     = l_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (final_tuple) begin
            state_d = DONE;
            i_d = ZERO;
            j_d = ZERO;
            k_d = ZERO;
            m_d = ZERO;
            n_d = ZERO;
            l_d = ZERO;
          end else begin
            l_d = wrap_l ? ZERO : l_q + ONE;
            if (wrap_l)
              n_d = wrap_n ? ZERO : n_q + ONE;
            if (wrap_l && wrap_n)
              m_d = wrap_m ? ZERO : m_q + ONE;
            if (wrap_l && wrap_n && wrap_m)
              k_d = wrap_k ? ZERO : k_q + ONE;
            if (wrap_l && wrap_n && wrap_m && wrap_k)
              j_d = wrap_j ? ZERO : j_q + ONE;
            if (wrap_l && wrap_n && wrap_m && wrap_k && wrap_j)
              i_d = i_q + ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Padded input coordinates of the current tuple, in 16 bits so they never wrap.
  always_comb begin
    row = STRIDE16 * 16'(j_q) + 16'(m_q);
    col = STRIDE16 * 16'(k_q) + 16'(n_q);
  end

  assign run       = (state_q == RUN);
  assign busy      = run;
  assign iter_en   = run;
  assign done      = (state_q == DONE);
  assign i         = i_q;
  assign j         = j_q;
  assign k         = k_q;
  assign m         = m_q;
  assign n         = n_q;
  assign l         = l_q;
  assign acc_clr   = run && (m_q == ZERO) && (n_q == ZERO) && (l_q == ZERO);
  assign acc_last  = run && wrap_m && wrap_n && wrap_l;
  assign in_bounds = run && axis_ok(row) && axis_ok(col);

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Bench for conv_loop_ctrl: two instances (the small reference config and a
// strided, padded config) driven with random stalls/starts and compared each
// cycle against a linear-tuple-count reference model.
module tb_conv_loop_ctrl;

  localparam int A_OCH = 2, A_OUT = 2, A_K = 2, A_CH = 2, A_IMG = 2, A_STR = 1, A_PAD = 0;
  localparam int B_OCH = 2, B_OUT = 3, B_K = 3, B_CH = 1, B_IMG = 5, B_STR = 2, B_PAD = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n, start, stall;

  logic       busy_a, done_a, iter_a, clr_a, last_a, ib_a;
  logic [7:0] i_a, j_a, k_a, m_a, n_a, l_a;
  logic       busy_b, done_b, iter_b, clr_b, last_b, ib_b;
  logic [7:0] i_b, j_b, k_b, m_b, n_b, l_b;

  int n_cmp = 0;
  int n_bad = 0;

  conv_loop_ctrl #(
    .BYTE(8), .CONV_DIM_IMG(A_IMG), .CONV_DIM_OUT(A_OUT), .CONV_DIM_KERNEL(A_K),
    .CONV_DIM_CH(A_CH), .CONV_OUT_CH(A_OCH), .STRIDE(A_STR), .PADDING(A_PAD)
  ) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .stall(stall[0]),
    .busy(busy_a), .done(done_a), .iter_en(iter_a),
    .i(i_a), .j(j_a), .k(k_a), .m(m_a), .n(n_a), .l(l_a),
    .acc_clr(clr_a), .acc_last(last_a), .in_bounds(ib_a)
  );

  conv_loop_ctrl #(
    .BYTE(8), .CONV_DIM_IMG(B_IMG), .CONV_DIM_OUT(B_OUT), .CONV_DIM_KERNEL(B_K),
    .CONV_DIM_CH(B_CH), .CONV_OUT_CH(B_OCH), .STRIDE(B_STR), .PADDING(B_PAD)
  ) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .stall(stall[1]),
    .busy(busy_b), .done(done_b), .iter_en(iter_b),
    .i(i_b), .j(j_b), .k(k_b), .m(m_b), .n(n_b), .l(l_b),
    .acc_clr(clr_b), .acc_last(last_b), .in_bounds(ib_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [53:0] snap(input int d);
    if (d == 0)
      return {busy_a, done_a, iter_a, clr_a, last_a, ib_a, i_a, j_a, k_a, m_a, n_a, l_a};
    return {busy_b, done_b, iter_b, clr_b, last_b, ib_b, i_b, j_b, k_b, m_b, n_b, l_b};
  endfunction

  function automatic int c_och(input int d); return (d == 0) ? A_OCH : B_OCH; endfunction
  function automatic int c_out(input int d); return (d == 0) ? A_OUT : B_OUT; endfunction
  function automatic int c_k  (input int d); return (d == 0) ? A_K   : B_K;   endfunction
  function automatic int c_ch (input int d); return (d == 0) ? A_CH  : B_CH;  endfunction
  function automatic int c_img(input int d); return (d == 0) ? A_IMG : B_IMG; endfunction
  function automatic int c_str(input int d); return (d == 0) ? A_STR : B_STR; endfunction
  function automatic int c_pad(input int d); return (d == 0) ? A_PAD : B_PAD; endfunction

  // Reference: ph 0=idle 1=run 2=done; t = linear tuple number within the pass.
  task automatic check_state(input int d, input int ph, input int t);
    logic [53:0] o;
    int ei, ej, ek, em, en, el, r, pix, row, col, run;
    string p;
    p   = (d == 0) ? "A_" : "B_";
    o   = snap(d);
    run = (ph == 1) ? 1 : 0;
    pix = c_k(d) * c_k(d) * c_ch(d);
    ei = 0; ej = 0; ek = 0; em = 0; en = 0; el = 0;
    if (run == 1) begin
      el = t % c_ch(d);  r = t / c_ch(d);
      en = r % c_k(d);   r = r / c_k(d);
      em = r % c_k(d);   r = r / c_k(d);
      ek = r % c_out(d); r = r / c_out(d);
      ej = r % c_out(d); ei = r / c_out(d);
    end
    row = c_str(d) * ej + em;
    col = c_str(d) * ek + en;
    chk({p, "busy"},     int'(o[53]), run);
    chk({p, "done"},     int'(o[52]), (ph == 2) ? 1 : 0);
    chk({p, "iter_en"},  int'(o[51]), run);
    chk({p, "acc_clr"},  int'(o[50]), (run == 1 && (t % pix) == 0) ? 1 : 0);
    chk({p, "acc_last"}, int'(o[49]), (run == 1 && (t % pix) == pix - 1) ? 1 : 0);
    chk({p, "in_bounds"}, int'(o[48]),
        (run == 1 && row >= c_pad(d) && row - c_pad(d) < c_img(d) &&
         col >= c_pad(d) && col - c_pad(d) < c_img(d)) ? 1 : 0);
    chk({p, "i"}, int'(o[47:40]), ei);
    chk({p, "j"}, int'(o[39:32]), ej);
    chk({p, "k"}, int'(o[31:24]), ek);
    chk({p, "m"}, int'(o[23:16]), em);
    chk({p, "n"}, int'(o[15:8]),  en);
    chk({p, "l"}, int'(o[7:0]),   el);
  endtask

  // mode 0: random stalls/starts (stall_pct), 1: stall 3 cycles at tuple 10,
  // 2: reset at tuple 20, 3: start pulsed mid-run and in the done cycle.
  task automatic run_pass(input int d, input int mode, input int stall_pct);
    int ph, t, nit, nstall, nclr, nlast, ndone, cyc, total, pix;
    bit sl, st, rs;
    logic [53:0] o;
    total = c_och(d) * c_out(d) * c_out(d) * c_k(d) * c_k(d) * c_ch(d);
    pix   = c_k(d) * c_k(d) * c_ch(d);
    for (int c = 0; c < 2; c++) begin
      stall[d] = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      check_state(d, 0, 0);
    end
    stall[d] = 1'b0;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    ph = 1; t = 0; nit = 0; nstall = 0; nclr = 0; nlast = 0; ndone = 0; cyc = 0;
    while (cyc < 4000) begin
      check_state(d, ph, t);
      if (ph == 0) break;
      if (ph == 1) nit++;
      if (ph == 2) ndone++;
      sl = 1'b0; st = 1'b0; rs = 1'b0;
      case (mode)
        1: sl = (ph == 1 && t == 10 && nstall < 3);
        2: rs = (ph == 1 && t == 20);
        3: st = (ph == 1 && t == 5) || (ph == 2);
        default: begin
          sl = ($urandom_range(99, 0) < stall_pct);
          st = (stall_pct > 0) && ($urandom_range(7, 0) == 0);
        end
      endcase
      o = snap(d);
      if (ph == 1 && sl) nstall++;
      if (ph == 1 && !sl && o[50]) nclr++;
      if (ph == 1 && !sl && o[49]) nlast++;
      stall[d] = sl;
      start[d] = st;
      rst_n[d] = !rs;
      if (rs) begin
        ph = 0; t = 0;
      end else if (ph == 1) begin
        if (!sl) begin
          if (t == total - 1) begin ph = 2; t = 0; end
          else t++;
        end
      end else if (ph == 2) begin
        ph = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    stall[d] = 1'b0;
    start[d] = 1'b0;
    rst_n[d] = 1'b1;
    chk("timeout",     (cyc < 4000) ? 1 : 0, 1);
    chk("pass_len",    nit,   (mode == 2) ? 21 : total + nstall);
    chk("done_pulses", ndone, (mode == 2) ? 0 : 1);
    chk("acc_clr_cnt", nclr,  (mode == 2) ? 20 / pix + 1 : total / pix);
    chk("acc_last_cnt", nlast, (mode == 2) ? 21 / pix : total / pix);
  endtask

  initial begin
    rst_n = 2'b00;
    start = 2'b00;
    stall = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_state(0, 0, 0);
    check_state(1, 0, 0);
    rst_n = 2'b11;
    @(posedge clk); #1;
    check_state(0, 0, 0);
    check_state(1, 0, 0);

    run_pass(0, 0, 0);
    run_pass(0, 1, 0);
    run_pass(0, 2, 0);
    run_pass(0, 0, 0);
    run_pass(0, 3, 0);
    run_pass(0, 0, 25);
    run_pass(0, 0, 50);
    run_pass(1, 0, 0);
    run_pass(1, 0, 30);
    run_pass(1, 3, 0);
    run_pass(1, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
